// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR burst generator: FSM states,
// feedback-style selectors and reference tap masks.
package lfsr_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    // Maximal-length masks; bit i set means state bit i feeds back.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hC410;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step next-state function, Fibonacci or Galois.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16),
    parameter int               MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (MODE == LFSR_GAL) begin : g_galois
            assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? TAPS : '0);
        end else begin : g_fib
            assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_burst_gen.sv
// Burst pattern generator: one command emits burst_len LFSR words on a
// valid/ready stream, with runtime reseed and zero-seed substitution.
module lfsr_burst_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hAAAA),
    parameter int               MODE  = LFSR_FIB,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen_cmd,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             dout_ready,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dataout,
    output logic             busy,
    output logic             lockup
);

    state_t           state, state_n;
    logic [WIDTH-1:0] lfsr_q, lfsr_n, load_val, step_in, step_out;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic             valid_n, lockup_n, seed_take;

    // A same-cycle seed load feeds the stepper directly so the first word
    // of a burst is one step past the new seed.
    assign seed_take = (state == IDLE) && seed_load;
    assign load_val  = (seed_val == '0) ? SEED : seed_val;
    assign step_in   = seed_take ? load_val : lfsr_q;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_step (
        .cur(step_in),
        .nxt(step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr_q     <= SEED;
            rem_q      <= '0;
            dout_valid <= 1'b0;
            lockup     <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr_q     <= lfsr_n;
            rem_q      <= rem_n;
            dout_valid <= valid_n;
            lockup     <= lockup_n;
        end
    end

    always_comb begin
        state_n  = state;
        lfsr_n   = lfsr_q;
        rem_n    = rem_q;
        valid_n  = dout_valid;
        lockup_n = 1'b0;
        case (state)
            IDLE: begin
                if (seed_load) begin
                    lfsr_n   = load_val;
                    lockup_n = (seed_val == '0);
                end
                if (gen_cmd && (burst_len != '0)) begin
                    lfsr_n  = step_out;
                    rem_n   = burst_len - CNT_W'(1);
                    valid_n = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (dout_valid && dout_ready) begin
                    if (rem_q != '0) begin
                        lfsr_n = step_out;
                        rem_n  = rem_q - CNT_W'(1);
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign dataout = lfsr_q;
    assign busy    = (state == RUN);

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Directed bench: default 16-bit Fibonacci instance plus an 8-bit Galois
// instance swept over its full period.
module tb_lfsr_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gen_cmd = 1'b0, seed_load = 1'b0, dout_ready = 1'b0;
    logic [7:0]  burst_len = '0;
    logic [15:0] seed_val = '0;
    logic        dout_valid, busy, lockup;
    logic [15:0] dataout;

    logic        g_gen = 1'b0, g_seed_load = 1'b0, g_ready = 1'b0;
    logic [7:0]  g_len = '0, g_seed_val = '0;
    logic        g_valid, g_busy, g_lockup;
    logic [7:0]  g_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_burst_gen dut (
        .clk(clk), .rst_n(rst_n), .gen_cmd(gen_cmd), .burst_len(burst_len),
        .seed_load(seed_load), .seed_val(seed_val), .dout_ready(dout_ready),
        .dout_valid(dout_valid), .dataout(dataout), .busy(busy), .lockup(lockup)
    );

    lfsr_burst_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hAA), .MODE(1), .CNT_W(8)) dut_gal (
        .clk(clk), .rst_n(rst_n), .gen_cmd(g_gen), .burst_len(g_len),
        .seed_load(g_seed_load), .seed_val(g_seed_val), .dout_ready(g_ready),
        .dout_valid(g_valid), .dataout(g_data), .busy(g_busy), .lockup(g_lockup)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        gen_cmd = 0; seed_load = 0; dout_ready = 0; burst_len = '0; seed_val = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dataout !== 16'hAAAA) begin errors++; $display("FAIL reset_data got=%h exp=aaaa", dataout); end
        checks++; if ({dout_valid, busy, lockup} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {dout_valid, busy, lockup}); end
    endtask

    task automatic test_burst();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h5555; exp_w[1] = 16'hAAAB; exp_w[2] = 16'h5557;
        do_reset();
        gen_cmd = 1; burst_len = 8'd3; dout_ready = 1;
        tick();
        gen_cmd = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (!(dout_valid === 1'b1 && busy === 1'b1 && dataout === exp_w[i])) begin
                errors++; $display("FAIL burst_w%0d got v=%b b=%b d=%h exp v=1 b=1 d=%h", i, dout_valid, busy, dataout, exp_w[i]); end
            tick();
        end
        checks++; if ({dout_valid, busy} !== 2'b00) begin errors++; $display("FAIL burst_end got=%b exp=00", {dout_valid, busy}); end
    endtask

    task automatic test_backpressure();
        int words = 0;
        do_reset();
        gen_cmd = 1; burst_len = 8'd3; dout_ready = 0;
        tick();
        gen_cmd = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (!(dout_valid === 1'b1 && dataout === 16'h5555)) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=5555", i, dout_valid, dataout); end
            tick();
        end
        dout_ready = 1;
        for (int i = 0; i < 6 && dout_valid; i++) begin
            if (i == 1) begin
                checks++; if (dataout !== 16'hAAAB) begin errors++; $display("FAIL bp_w1 got=%h exp=aaab", dataout); end
            end
            words++;
            tick();
        end
        checks++; if (words != 3) begin errors++; $display("FAIL bp_words got=%0d exp=3", words); end
        checks++; if (dataout !== 16'h5557) begin errors++; $display("FAIL bp_last got=%h exp=5557", dataout); end
    endtask

    task automatic test_seed_load();
        do_reset();
        seed_load = 1; seed_val = 16'h0001;
        tick();
        seed_load = 0;
        checks++; if (!(dataout === 16'h0001 && lockup === 1'b0)) begin errors++; $display("FAIL seed_load got d=%h l=%b exp d=0001 l=0", dataout, lockup); end
        gen_cmd = 1; burst_len = 8'd1; dout_ready = 1;
        tick();
        gen_cmd = 0;
        checks++; if (!(dout_valid === 1'b1 && dataout === 16'h0002)) begin errors++; $display("FAIL seed_step got v=%b d=%h exp v=1 d=0002", dout_valid, dataout); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL seed_len1_end got=%b exp=0", dout_valid); end
        // Load and command together: first word is one step past the new seed.
        seed_load = 1; seed_val = 16'h0001; gen_cmd = 1; burst_len = 8'd1;
        tick();
        seed_load = 0; gen_cmd = 0;
        checks++; if (!(dout_valid === 1'b1 && dataout === 16'h0002)) begin errors++; $display("FAIL seed_same_cycle got v=%b d=%h exp v=1 d=0002", dout_valid, dataout); end
        tick();
    endtask

    task automatic test_lockup();
        do_reset();
        seed_load = 1; seed_val = 16'h1234;
        tick();
        seed_val = 16'h0000;
        tick();
        seed_load = 0;
        checks++; if (!(lockup === 1'b1 && dataout === 16'hAAAA)) begin errors++; $display("FAIL lockup_pulse got l=%b d=%h exp l=1 d=aaaa", lockup, dataout); end
        tick();
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL lockup_clear got=%b exp=0", lockup); end
        gen_cmd = 1; burst_len = 8'd2; dout_ready = 1;
        tick();
        gen_cmd = 0;
        checks++; if (dataout !== 16'h5555) begin errors++; $display("FAIL lockup_w0 got=%h exp=5555", dataout); end
        tick();
        checks++; if (dataout !== 16'hAAAB) begin errors++; $display("FAIL lockup_w1 got=%h exp=aaab", dataout); end
        tick();
    endtask

    task automatic test_run_ignore();
        do_reset();
        gen_cmd = 1; burst_len = 8'd3; dout_ready = 1;
        tick();
        burst_len = 8'd5; seed_load = 1; seed_val = 16'h1234;
        tick();
        checks++; if (dataout !== 16'hAAAB) begin errors++; $display("FAIL ign_w1 got=%h exp=aaab", dataout); end
        tick();
        checks++; if (dataout !== 16'h5557) begin errors++; $display("FAIL ign_w2 got=%h exp=5557", dataout); end
        gen_cmd = 0; seed_load = 0;
        tick();
        checks++; if (!(dout_valid === 1'b0 && busy === 1'b0 && dataout === 16'h5557)) begin
            errors++; $display("FAIL ign_end got v=%b b=%b d=%h exp v=0 b=0 d=5557", dout_valid, busy, dataout); end
        gen_cmd = 1; burst_len = 8'd0;
        tick();
        gen_cmd = 0;
        checks++; if (!(dout_valid === 1'b0 && busy === 1'b0 && dataout === 16'h5557)) begin
            errors++; $display("FAIL zero_len got v=%b b=%b d=%h exp v=0 b=0 d=5557", dout_valid, busy, dataout); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        gen_cmd = 1; burst_len = 8'd5; dout_ready = 1;
        tick();
        gen_cmd = 0;
        tick();
        checks++; if (dataout !== 16'hAAAB) begin errors++; $display("FAIL mid_w1 got=%h exp=aaab", dataout); end
        rst_n = 1'b0;
        #1;
        checks++; if (!(dout_valid === 1'b0 && busy === 1'b0 && dataout === 16'hAAAA)) begin
            errors++; $display("FAIL mid_reset got v=%b b=%b d=%h exp v=0 b=0 d=aaaa", dout_valid, busy, dataout); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (!(dout_valid === 1'b0 && busy === 1'b0)) begin errors++; $display("FAIL mid_no_resume got v=%b b=%b exp 0 0", dout_valid, busy); end
    endtask

    task automatic test_galois();
        logic [255:0] seen = '0;
        do_reset();
        g_gen = 1; g_len = 8'd255; g_ready = 1;
        tick();
        g_gen = 0;
        for (int i = 0; i < 255; i++) begin
            checks++; if (!(g_valid === 1'b1 && g_data !== 8'h00 && !seen[g_data])) begin
                errors++; $display("FAIL gal_w%0d got v=%b d=%h seen=%b exp v=1 unseen nonzero", i, g_valid, g_data, seen[g_data]); end
            seen[g_data] = 1'b1;
            tick();
        end
        checks++; if (!(g_valid === 1'b0 && g_busy === 1'b0)) begin errors++; $display("FAIL gal_end got v=%b b=%b exp 0 0", g_valid, g_busy); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_seed_load();
        test_lockup();
        test_run_ignore();
        test_reset_mid();
        test_galois();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_gen.md
# lfsr_burst_gen

Parametrised pseudo-random pattern generator for the off-chip traffic path. It is the successor to the single-step 16-bit Fibonacci LFSR: width, taps, seed and feedback style are configurable. A single command produces a burst of N words on a valid/ready stream, with runtime reseeding and all-zero lockup protection. It feeds the off-chip write datapath and drives `dout_valid` as that path's write strobe.

## Interface
Parameters:
- `WIDTH`, 16, LFSR and data width (>= 4)
- `TAPS`, 16'hC410, feedback mask; bit i set = state bit i participates (bits 15,14,10,4 at default)
- `SEED`, 16'hAAAA, reset/fallback state; must be nonzero
- `MODE`, 0, 0 = Fibonacci, 1 = Galois
- `CNT_W`, 8, burst-length counter width

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `gen_cmd` in 1 — start a burst (sampled in IDLE only)
- `burst_len` in CNT_W — words in burst, sampled with `gen_cmd`
- `seed_load` in 1 — load `seed_val` into LFSR (IDLE only)
- `seed_val` in WIDTH — runtime seed
- `dout_ready` in 1 — downstream accepts word
- `dout_valid` out 1 — `dataout` holds a valid word
- `dataout` out WIDTH — current LFSR state
- `busy` out 1 — high in RUN
- `lockup` out 1 — one-cycle pulse: zero seed replaced by `SEED`

## Operation
- Next-state function, Fibonacci: `{s[W-2:0], ^(s & TAPS)}`.
- Next-state function, Galois: `{s[W-2:0],1'b0} ^ (s[W-1] ? TAPS : 0)`. TAPS must include bit 0 in this mode.
- FSM states: IDLE, RUN.
- IDLE, `gen_cmd`=1 and `burst_len`!=0:
  - LFSR steps once; `dout_valid`<=1; `remaining`<=`burst_len`-1; go to RUN.
- IDLE, `gen_cmd`=1 and `burst_len`=0: ignored, no state change.
- RUN, each cycle:
  - Transfer occurs when `dout_valid`&&`dout_ready`.
  - On transfer with `remaining`!=0: step LFSR, keep `dout_valid`=1, decrement `remaining`.
  - On transfer with `remaining`=0: `dout_valid`<=0, go to IDLE.
  - No transfer: LFSR, `dataout` and `remaining` hold (backpressure).
- `gen_cmd` and `seed_load` are ignored in RUN.
- `seed_load` in IDLE:
  - LFSR <= `seed_val`.
  - If `seed_val`==0: LFSR <= `SEED` instead, and `lockup` pulses the next cycle.
- `seed_load` and `gen_cmd` in the same IDLE cycle: the first word is one step from the loaded (or substituted) seed, computed the same cycle.
- All-zero state is therefore unreachable.

## Timing
- Reset values: LFSR=`SEED`, `dataout`=`SEED`, `dout_valid`=0, `busy`=0, `lockup`=0, `remaining`=0, state IDLE.
- Latency: `gen_cmd` at edge k gives `dout_valid`=1 after edge k. `dataout` is then the first stepped value.
- Throughput with `dout_ready` held high: N words on N consecutive cycles. `busy` falls on the edge after the last transfer.
- `busy` equals (state==RUN). `dout_valid` is never high in IDLE.
- `dataout` is stable while `dout_valid` && !`dout_ready`.
- Counter wraps are not possible: the maximum burst is 2^CNT_W−1 words.
- `rst_n` asserted mid-burst: immediate return to reset values. The burst is lost, not resumed.

## Structure
- Shared package `lfsr_pkg` contains:
  - the state enum (IDLE, RUN),
  - the MODE constants `LFSR_FIB`/`LFSR_GAL`,
  - the default tap masks for widths 8/16/32.
- Sub-module `lfsr_step`: purely combinational next-state function, parametrised by WIDTH/TAPS/MODE. It is instanced once, with the input muxed between the current state and the loaded seed.
- FSM, counter and output registers live in `lfsr_burst_gen`.

## Test plan
- Reset, then `gen_cmd`, `burst_len`=3, `dout_ready`=1, defaults → `dataout` 16'h5555, 16'hAAAB, then the next step on 3 consecutive cycles; `busy` low the cycle after the third word.
- Same burst with `dout_ready` low for 4 cycles after the first word → 16'h5555 held 4 cycles; no step occurs; 3 total words.
- IDLE `seed_load`, `seed_val`=16'h0001, then `gen_cmd`, `burst_len`=1 → `dataout`=16'h0002 (Fibonacci; feedback 0).
- `seed_load`, `seed_val`=0 → `lockup` pulses once; LFSR=16'hAAAA; the next burst matches the post-reset sequence.
- `gen_cmd` and `seed_load` during RUN → ignored; sequence and word count unchanged. `burst_len`=0 in IDLE → no `dout_valid`.
- `rst_n` low for one cycle mid-burst (word 2 of 5) → `dout_valid`/`busy` low immediately; `dataout`=16'hAAAA. MODE=1 with WIDTH=8, TAPS=8'h1D run for 255 words → no repeat, no zero.
